fp32_argmax_sched: RTL and testbench
====================================

# fp32_argmax_sched

Sequential argmax controller for the SVR inference path. It accepts a vector of IEEE-754 single-precision scores over a valid/ready stream and time-shares one combinational fp32 greater-than comparator across all elements. It returns the maximum value and its index over an output valid/ready handshake. It sits between the score-producing datapath and the result/decision logic.

## Interface
- `N_MAX`, 16: maximum vector length; must be ≥ 2.
- `IDX_W`, $clog2(N_MAX): index width (derived localparam, not overridable).
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a vector; sampled only in IDLE.
- `len`  in  IDX_W+1  vector length, sampled with `start`; legal range 1..N_MAX.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  one-cycle pulse when `start` arrives with an illegal `len`.
- `in_valid`  in  1  input element valid.
- `in_ready`  out  1  high in FIRST and RUN.
- `in_data`  in  32  fp32 element.
- `out_valid`  out  1  result valid; held until accepted.
- `out_ready`  in  1  result consumer ready.
- `out_max`  out  32  maximum element.
- `out_idx`  out  IDX_W  zero-based index of the maximum.

## Operation
- States: IDLE, FIRST, RUN, DONE.
- IDLE:
  - `start` with legal `len`: latch `len`, clear the element counter, go to FIRST.
  - `start` with `len`==0 or `len`>N_MAX: pulse `err` the next cycle and stay in IDLE.
- FIRST: on `in_valid && in_ready`, load `in_data` into the max register and set index 0.
  - `len`==1: go to DONE.
  - Otherwise: go to RUN.
- RUN: on each handshake, compare `in_data` against the max register.
  - Strictly greater: replace max and index with the current counter value.
  - Equal: keep the earlier index (ties keep the first occurrence).
  - Last element (counter == `len`-1): go to DONE.
- DONE: `out_valid`=1 and `out_max`/`out_idx` stable. On `out_ready`, return to IDLE.
- Comparator ordering (sign-magnitude total order):
  - Signs differ: the positive operand is greater, so +0 > -0.
  - Both positive: larger {exponent, mantissa} is greater.
  - Both negative: smaller {exponent, mantissa} is greater.
  - Bit-identical operands: not greater.
  - NaN and Inf are not special-cased; they are ordered by bit pattern as above.
- `start` outside IDLE is ignored. `len` is not re-sampled mid-vector.

## Timing
- Reset values: state=IDLE, `busy`=0, `err`=0, `in_ready`=0, `out_valid`=0, `out_max`=32'h0, `out_idx`=0, counter=0.
- Throughput: one element accepted per cycle while `in_valid` is held high. No bubbles between elements.
- Latency: `out_valid` rises the cycle after the final element's handshake. A continuous N-element vector takes N+1 cycles from the first handshake to `out_valid`.
- `in_ready` is registered from the state and drops in the cycle after the last handshake. An `in_valid` presented while in DONE is not accepted.
- Output backpressure: `out_valid` and the data hold indefinitely while `out_ready`=0.
- Back-to-back vectors: a `start` can be taken no earlier than the cycle after the DONE→IDLE transition.
- Asynchronous reset mid-vector: immediately returns to the reset values above. The partial result is discarded, and no `out_valid` is produced.
- `err` and `busy` are registered outputs.

## Structure
- The package `fp32_pkg` holds:
  - the field constants SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MAN_MSB=22;
  - the state enum `argmax_state_t`.
- One sub-module, `fp32_gt_cmp`: a purely combinational strict-greater-than with the ordering above.
  - Inputs `a[31:0]` and `b[31:0]`, output `gt`.
  - Instantiated once, with a = `in_data` and b = the max register.
- The top level holds the FSM, counter, max/index registers and handshake logic.

## Test plan
- len=4, inputs 1.0 (3F800000), -2.0 (C0000000), 3.5 (40600000), 0.5 (3F000000), continuous valid, `out_ready`=1:
  - required response: out_max=40600000, out_idx=2;
  - `out_valid` 5 cycles after the first handshake.
- All negative, len=3, inputs -1.0 (BF800000), -0.25 (BE800000), -8.0 (C1000000): out_max=BE800000, out_idx=1.
- Tie and zero ordering, len=4, inputs -0 (80000000), +0 (00000000), 2.0 (40000000), 2.0: out_idx=2, out_max=40000000.
  - Separately, len=2 with inputs 80000000 then 00000000: out_idx=1.
- Length errors:
  - `len`=0 and `len`=N_MAX+1: one-cycle `err`, `busy` stays 0, no `in_ready`.
  - `len`=1 with input 7F800000: out_idx=0.
- Backpressure: random `in_valid` gaps and `out_ready` held low for 10 cycles.
  - Required response: result unchanged and held, `in_ready`=0 during DONE, a `start` during DONE ignored.
- Reset mid-op: deassert `rst_n` after 2 of 5 elements.
  - Required response: all outputs return to their reset values.
  - A new vector started after reset returns a correct result.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared fp32 field positions and argmax controller state encoding.
package fp32_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_MSB  = 22;

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        RUN,
        DONE
    } argmax_state_t;

endpackage

// File: rtl/fp32_gt_cmp.sv
// Strict a > b over fp32 bit patterns in sign-magnitude total order.
module fp32_gt_cmp
    import fp32_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        gt
);

    logic [30:0] ma;
    logic [30:0] mb;

    assign ma = {a[EXP_MSB:EXP_LSB], a[MAN_MSB:0]};
    assign mb = {b[EXP_MSB:EXP_LSB], b[MAN_MSB:0]};

    // NaN/Inf deliberately fall through to plain bit ordering
    always_comb begin
        gt = 1'b0;
        if (a[SIGN_BIT] != b[SIGN_BIT]) begin
            gt = b[SIGN_BIT];
        end else if (a[SIGN_BIT]) begin
            gt = (ma < mb);
        end else begin
            gt = (ma > mb);
        end
    end

endmodule

// File: rtl/fp32_argmax_sched.sv
// Streaming fp32 argmax: one shared comparator, one element per cycle.
module fp32_argmax_sched
    import fp32_pkg::*;
#(
    parameter  int N_MAX = 16,
    localparam int IDX_W = $clog2(N_MAX)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDX_W:0]   len,
    output logic             busy,
    output logic             err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_max,
    output logic [IDX_W-1:0] out_idx
);

    localparam logic [IDX_W:0] ONE     = (IDX_W+1)'(1);
    localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(N_MAX);

    argmax_state_t    state_q;
    argmax_state_t    state_n;
    logic [IDX_W:0]   len_q;
    logic [IDX_W:0]   cnt_q;
    logic [31:0]      max_q;
    logic [IDX_W-1:0] idx_q;
    logic             hs;
    logic             gt;
    logic             last;
    logic             len_bad;
    logic             take;

    fp32_gt_cmp u_cmp (
        .a  (in_data),
        .b  (max_q),
        .gt (gt)
    );

    assign hs      = in_valid && in_ready;
    assign last    = (cnt_q == len_q - ONE);
    assign len_bad = (len == '0) || (len > LEN_MAX);
    assign take    = (state_q == IDLE) && start && !len_bad;
    assign out_max = max_q;
    assign out_idx = idx_q;

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE:    if (take) state_n = FIRST;
            FIRST:   if (hs) state_n = (len_q == ONE) ? DONE : RUN;
            RUN:     if (hs && last) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // handshake flags are registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy      <= 1'b0;
            err       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_n;
            busy      <= (state_n != IDLE);
            err       <= (state_q == IDLE) && start && len_bad;
            in_ready  <= (state_n == FIRST) || (state_n == RUN);
            out_valid <= (state_n == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
            cnt_q <= '0;
            max_q <= 32'h0;
            idx_q <= '0;
        end else begin
            if (take) begin
                len_q <= len;
                cnt_q <= '0;
            end
            if (hs && state_q == FIRST) begin
                max_q <= in_data;
                idx_q <= '0;
                cnt_q <= ONE;
            end
            if (hs && state_q == RUN) begin
                // ties keep the first occurrence
                if (gt) begin
                    max_q <= in_data;
                    idx_q <= cnt_q[IDX_W-1:0];
                end
                cnt_q <= cnt_q + ONE;
            end
        end
    end

endmodule

// File: tb/tb_fp32_argmax_sched.sv
// Randomized bench for fp32_argmax_sched against an ordered-key argmax model.
module tb_fp32_argmax_sched;

    localparam int N  = 16;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [IW:0]   len = '0;
    logic          busy;
    logic          err;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data = 32'h0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_max;
    logic [IW-1:0] out_idx;

    int total = 0;
    int bad   = 0;

    fp32_argmax_sched #(.N_MAX(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .err       (err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_idx   (out_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // map fp32 bits to an unsigned key whose order matches the spec ordering
    function automatic logic [31:0] okey(input logic [31:0] x);
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction

    task automatic model(input logic [31:0] v[$], output logic [31:0] m,
                         output int ix);
        m  = v[0];
        ix = 0;
        for (int k = 1; k < v.size(); k++)
            if (okey(v[k]) > okey(m)) begin
                m  = v[k];
                ix = k;
            end
    endtask

    task automatic run_vec(input logic [31:0] v[$], input int gap,
                           input int hold);
        int n = v.size();
        int i = 0;
        int lat = 0;
        int budget = 0;
        int eidx;
        logic hs;
        logic [31:0] emax;
        model(v, emax, eidx);
        out_ready = (hold == 0);
        @(negedge clk);
        start = 1'b1;
        len = (IW+1)'(n);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        while (i < n && budget < 500) begin
            in_valid = ($urandom_range(99) >= gap);
            in_data = v[i];
            hs = in_valid && in_ready;
            if (hs || lat > 0) lat++;
            @(negedge clk);
            budget++;
            if (hs) i++;
        end
        in_valid = 1'b0;
        in_data = $urandom;
        while (!out_valid && budget < 500) begin
            lat++;
            @(negedge clk);
            budget++;
        end
        lat++;
        chk("out_valid_timeout", out_valid, 1);
        if (gap == 0) chk("latency", lat, n + 1);
        chk("out_max", out_max, emax);
        chk("out_idx", out_idx, eidx);
        chk("in_ready_done", in_ready, 0);
        if (hold > 0) begin
            in_valid = 1'b1;
            in_data = 32'h7f7f_ffff;
            start = 1'b1;
            len = (IW+1)'(1);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                start = 1'b0;
                chk("hold_valid", out_valid, 1);
                chk("hold_max", out_max, emax);
                chk("hold_idx", out_idx, eidx);
                chk("hold_in_ready", in_ready, 0);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk("released_valid", out_valid, 0);
        chk("released_busy", busy, 0);
        out_ready = 1'b1;
    endtask

    task automatic bad_len(input logic [IW:0] l);
        @(negedge clk);
        start = 1'b1;
        len = l;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        chk("err_in_ready", in_ready, 0);
        @(negedge clk);
        chk("err_clear", err, 0);
        chk("err_busy2", busy, 0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_max", out_max, 0);
        chk("rst_out_idx", out_idx, 0);
    endtask

    logic [31:0] pool [7] = '{32'h0000_0000, 32'h8000_0000, 32'h3f80_0000,
                              32'hbf80_0000, 32'h7f80_0000, 32'hff80_0000,
                              32'h7fc0_0000};

    initial begin
        logic [31:0] v[$];
        #12;
        chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;

        v = '{32'h3f80_0000, 32'hc000_0000, 32'h4060_0000, 32'h3f00_0000};
        run_vec(v, 0, 0);
        v = '{32'hbf80_0000, 32'hbe80_0000, 32'hc100_0000};
        run_vec(v, 0, 0);
        v = '{32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 32'h4000_0000};
        run_vec(v, 0, 0);
        v = '{32'h8000_0000, 32'h0000_0000};
        run_vec(v, 0, 0);

        bad_len('0);
        bad_len((IW+1)'(N + 1));
        v = '{32'h7f80_0000};
        run_vec(v, 0, 0);

        v = '{32'h4000_0000, 32'h4100_0000, 32'hc200_0000, 32'h4100_0000,
              32'h3f00_0000, 32'h40a0_0000};
        run_vec(v, 40, 10);

        @(negedge clk);
        start = 1'b1;
        len = (IW+1)'(5);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h4200_0000;
        @(negedge clk);
        in_data = 32'h4300_0000;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_valid", out_valid, 0);
        end
        v = '{32'h3f00_0000, 32'hbf00_0000, 32'h4080_0000, 32'h4080_0000,
              32'h0000_0000};
        run_vec(v, 0, 0);

        for (int t = 0; t < 20; t++) begin
            int n = $urandom_range(N, 1);
            v = {};
            for (int k = 0; k < n; k++)
                v.push_back(($urandom_range(99) < 40)
                            ? pool[$urandom_range(6)] : $urandom);
            run_vec(v, ($urandom_range(1) != 0) ? 30 : 0,
                    ($urandom_range(3) == 0) ? 3 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
